// File: rtl/b06_eql_gen_if.sv
// ---------------------------------------------------------------------------
// b06_eql_gen_if
//   Bundle of the request and handler-loop signals around b06_eql_gen.
//   Signal names follow the b06 handler naming so both sides read alike.
//
//   Parameter:
//     CNT_W        width of REQ_TARGET
//   Signals (direction as seen by the equality generator, modport slave):
//     REQ_VALID    in   request offered
//     REQ_TARGET   in   count at which EQL fires
//     REQ_READY    out  block idle, request accepted on REQ_VALID & REQ_READY
//     ENABLE_COUNT in   from handler: advance counter
//     ACKOUT       in   from handler: acknowledge of match
//     USCITE       in   from handler: result code, sampled on ACKOUT
//     EQL          out  counter equals target
//     CONT_EQL     out  equality held for at least two cycles
//     DONE_VALID   out  one-cycle completion pulse
//     DONE_CODE    out  captured USCITE, or 2'b00 on timeout
//     TIMEOUT_ERR  out  sticky timeout flag
//   Modport master is the request source / handler side.
// ---------------------------------------------------------------------------
interface b06_eql_gen_if #(
  parameter int CNT_W = 4
);
  logic             REQ_VALID;
  logic [CNT_W-1:0] REQ_TARGET;
  logic             REQ_READY;
  logic             ENABLE_COUNT;
  logic             ACKOUT;
  logic [1:0]       USCITE;
  logic             EQL;
  logic             CONT_EQL;
  logic             DONE_VALID;
  logic [1:0]       DONE_CODE;
  logic             TIMEOUT_ERR;

  modport master (
    output REQ_VALID, REQ_TARGET, ENABLE_COUNT, ACKOUT, USCITE,
    input  REQ_READY, EQL, CONT_EQL, DONE_VALID, DONE_CODE, TIMEOUT_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_TARGET, ENABLE_COUNT, ACKOUT, USCITE,
    output REQ_READY, EQL, CONT_EQL, DONE_VALID, DONE_CODE, TIMEOUT_ERR
  );
endinterface

// File: rtl/b06_eql_gen.sv
// ---------------------------------------------------------------------------
// b06_eql_gen
//   Request-side peer of the b06 interrupt-handler FSM. Accepts a target
//   count, advances a counter while the handler asserts ENABLE_COUNT, raises
//   EQL / CONT_EQL on match, completes a four-phase handshake on ACKOUT and
//   captures USCITE as the result code.
//
//   Ports:
//     CLOCK    in  single clock, rising edge
//     RESET    in  asynchronous, active-high reset
//     eql_if   b06_eql_gen_if.slave, request and handler-loop signals
//   Parameters:
//     CNT_W    width of target and counter
//     TIMEOUT  MATCH cycles before forced completion, 1..255
//   Build option:
//     B06_EQL_TIMEOUT_EN  when defined, an 8-bit MATCH watchdog forces a
//                         completion with DONE_CODE=2'b00 and sets the sticky
//                         TIMEOUT_ERR; when undefined, MATCH waits forever
//                         and TIMEOUT_ERR is tied low.
// ---------------------------------------------------------------------------
module b06_eql_gen #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input logic          CLOCK,
  input logic          RESET,
  b06_eql_gen_if.slave eql_if
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd1;
  localparam logic [1:0] ST_MATCH   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             eql_q, eql_d;
  logic             cont_eql_q, cont_eql_d;
  logic             done_valid_q, done_valid_d;
  logic [1:0]       done_code_q, done_code_d;

`ifdef B06_EQL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic       timeout_err_q, timeout_err_d;
  logic [7:0] wdog_q, wdog_d;
  logic [7:0] wdog_inc_s;

  // Watchdog value after counting the current MATCH cycle
  assign wdog_inc_s = wdog_q + 8'd1;
`else
  // Gives TIMEOUT a reader in the watchdog-free build
  logic timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT > 0);
`endif

  // Next-state and output-register logic for the handshake FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tgt_d        = tgt_q;
    eql_d        = eql_q;
    cont_eql_d   = cont_eql_q;
    done_valid_d = 1'b0;
    done_code_d  = done_code_q;
`ifdef B06_EQL_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
    wdog_d        = wdog_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (eql_if.REQ_VALID) begin
          tgt_d   = eql_if.REQ_TARGET;
          cnt_d   = CNT_ZERO;
          state_d = ST_COUNT;
`ifdef B06_EQL_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_COUNT: begin
        // Equality is checked before counting, so cnt never passes tgt
        if (cnt_q == tgt_q) begin
          eql_d   = 1'b1;
          state_d = ST_MATCH;
`ifdef B06_EQL_TIMEOUT_EN
          wdog_d = 8'd0;
`endif
        end else if (eql_if.ENABLE_COUNT) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_MATCH: begin
        // ACKOUT has priority over a watchdog expiry on the same edge
        if (eql_if.ACKOUT) begin
          done_code_d  = eql_if.USCITE;
          done_valid_d = 1'b1;
          eql_d        = 1'b0;
          cont_eql_d   = 1'b0;
          state_d      = ST_RELEASE;
        end
`ifdef B06_EQL_TIMEOUT_EN
        else if (wdog_inc_s == TIMEOUT_C) begin
          // Forced completion returns straight to IDLE: no ACKOUT to wait on
          done_code_d   = 2'b00;
          done_valid_d  = 1'b1;
          timeout_err_d = 1'b1;
          eql_d         = 1'b0;
          cont_eql_d    = 1'b0;
          state_d       = ST_IDLE;
        end
`endif
        else begin
          cont_eql_d = 1'b1;
`ifdef B06_EQL_TIMEOUT_EN
          wdog_d = wdog_inc_s;
`endif
        end
      end

      ST_RELEASE: begin
        if (!eql_if.ACKOUT) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      tgt_q        <= CNT_ZERO;
      eql_q        <= 1'b0;
      cont_eql_q   <= 1'b0;
      done_valid_q <= 1'b0;
      done_code_q  <= 2'b00;
`ifdef B06_EQL_TIMEOUT_EN
      timeout_err_q <= 1'b0;
      wdog_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      eql_q        <= eql_d;
      cont_eql_q   <= cont_eql_d;
      done_valid_q <= done_valid_d;
      done_code_q  <= done_code_d;
`ifdef B06_EQL_TIMEOUT_EN
      timeout_err_q <= timeout_err_d;
      wdog_q        <= wdog_d;
`endif
    end
  end

  // REQ_READY is the only output decoded combinationally from state
  assign eql_if.REQ_READY  = (state_q == ST_IDLE);
  assign eql_if.EQL        = eql_q;
  assign eql_if.CONT_EQL   = cont_eql_q;
  assign eql_if.DONE_VALID = done_valid_q;
  assign eql_if.DONE_CODE  = done_code_q;
`ifdef B06_EQL_TIMEOUT_EN
  assign eql_if.TIMEOUT_ERR = timeout_err_q;
`else
  assign eql_if.TIMEOUT_ERR = 1'b0;
`endif

endmodule
